// File: rtl/mux_sel_arbiter_4.sv
// Round-robin arbiter for a shared 4:1 select-driven mux: registered one-hot
// grant, matching select, and a hold limit that forces rotation under contention.
module mux_sel_arbiter_4 #(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] sel,
    output logic       valid,
    output logic [7:0] hold_cnt
);

    typedef enum logic {IDLE, BUSY} state_t;

    // With no limit the counter simply saturates at its full range.
    localparam logic [7:0] HOLD_LAST = (MAX_HOLD == 0) ? 8'd255 : 8'(MAX_HOLD - 1);
    localparam bit         LIMIT_EN  = (MAX_HOLD != 0);

    state_t     state;
    logic [1:0] ptr;
    logic [1:0] next_ptr;
    logic [2:0] idle_pick;
    logic [2:0] rot_pick;
    logic       owner_req;
    logic       at_limit;

    // Returns {found, index} of the first set bit scanning cyclically from start.
    function automatic logic [2:0] pick(input logic [3:0] r, input logic [1:0] start);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int k = 3; k >= 0; k--) begin
            idx = start + 2'(k);
            if (r[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    always_comb begin
        next_ptr  = sel + 2'd1;
        owner_req = req[sel];
        at_limit  = (hold_cnt == HOLD_LAST);
        idle_pick = pick(req, ptr);
        // Masking the owner means a forced rotation can never re-pick it.
        rot_pick  = pick(req & ~gnt, next_ptr);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= 2'd0;
            gnt      <= 4'b0000;
            sel      <= 2'd0;
            valid    <= 1'b0;
            hold_cnt <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (idle_pick[2]) begin
                        state    <= BUSY;
                        gnt      <= 4'b0001 << idle_pick[1:0];
                        sel      <= idle_pick[1:0];
                        valid    <= 1'b1;
                        hold_cnt <= 8'd0;
                    end else begin
                        // sel deliberately keeps its last value so the mux output is stable.
                        gnt      <= 4'b0000;
                        valid    <= 1'b0;
                        hold_cnt <= 8'd0;
                    end
                end
                BUSY: begin
                    if (!owner_req) begin
                        ptr      <= next_ptr;
                        hold_cnt <= 8'd0;
                        if (rot_pick[2]) begin
                            gnt   <= 4'b0001 << rot_pick[1:0];
                            sel   <= rot_pick[1:0];
                            valid <= 1'b1;
                        end else begin
                            state <= IDLE;
                            gnt   <= 4'b0000;
                            valid <= 1'b0;
                        end
                    end else if (LIMIT_EN && at_limit && rot_pick[2]) begin
                        ptr      <= next_ptr;
                        gnt      <= 4'b0001 << rot_pick[1:0];
                        sel      <= rot_pick[1:0];
                        valid    <= 1'b1;
                        hold_cnt <= 8'd0;
                    end else if (!at_limit) begin
                        hold_cnt <= hold_cnt + 8'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    gnt   <= 4'b0000;
                    valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux_sel_arbiter_4.sv
// Directed table-driven bench for mux_sel_arbiter_4 (MAX_HOLD=4), plus a
// hand-written sequence against a second instance with the hold limit disabled.
module tb_mux_sel_arbiter_4;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic [3:0] gnt4, gnt0;
    logic [1:0] sel4, sel0;
    logic       valid4, valid0;
    logic [7:0] hold4, hold0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mux_sel_arbiter_4 #(.MAX_HOLD(4)) dut (
        .clk(clk), .rst(rst), .req(req),
        .gnt(gnt4), .sel(sel4), .valid(valid4), .hold_cnt(hold4)
    );

    mux_sel_arbiter_4 #(.MAX_HOLD(0)) dut_nolim (
        .clk(clk), .rst(rst), .req(req),
        .gnt(gnt0), .sel(sel0), .valid(valid0), .hold_cnt(hold0)
    );

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [3:0] gnt;
        logic [1:0] sel;
        logic       valid;
        logic [7:0] hold;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic [3:0] q, input logic [3:0] g,
                       input logic [1:0] s, input logic v, input logic [7:0] h);
        vec_t e;
        e.rst = r; e.req = q; e.gnt = g; e.sel = s; e.valid = v; e.hold = h;
        vecs.push_back(e);
    endtask

    task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic [3:0] q);
        rst = r;
        req = q;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        req = 4'b0000;

        // reset with all requesting
        add(1, 4'b1111, 4'b0000, 2'd0, 0, 8'd0);
        add(1, 4'b1111, 4'b0000, 2'd0, 0, 8'd0);
        add(0, 4'b1111, 4'b0001, 2'd0, 1, 8'd0);
        // round robin, each owner drops for one cycle
        add(0, 4'b1110, 4'b0010, 2'd1, 1, 8'd0);
        add(0, 4'b1101, 4'b0100, 2'd2, 1, 8'd0);
        add(0, 4'b1011, 4'b1000, 2'd3, 1, 8'd0);
        add(0, 4'b0111, 4'b0001, 2'd0, 1, 8'd0);
        // owner 2 holds, then hands over to 1 with no bubble
        add(0, 4'b0100, 4'b0100, 2'd2, 1, 8'd0);
        add(0, 4'b0110, 4'b0100, 2'd2, 1, 8'd1);
        add(0, 4'b0010, 4'b0010, 2'd1, 1, 8'd0);
        // hold limit: owner 0 forced off after 4 cycles by requester 3
        add(0, 4'b0001, 4'b0001, 2'd0, 1, 8'd0);
        add(0, 4'b1001, 4'b0001, 2'd0, 1, 8'd1);
        add(0, 4'b1001, 4'b0001, 2'd0, 1, 8'd2);
        add(0, 4'b1001, 4'b0001, 2'd0, 1, 8'd3);
        add(0, 4'b1001, 4'b1000, 2'd3, 1, 8'd0);
        add(0, 4'b0001, 4'b0001, 2'd0, 1, 8'd0);
        // saturation with no contender
        add(0, 4'b0010, 4'b0010, 2'd1, 1, 8'd0);
        add(0, 4'b0010, 4'b0010, 2'd1, 1, 8'd1);
        add(0, 4'b0010, 4'b0010, 2'd1, 1, 8'd2);
        for (int i = 0; i < 7; i++) add(0, 4'b0010, 4'b0010, 2'd1, 1, 8'd3);
        // mid-grant reset with owner 3 at hold_cnt 2
        add(0, 4'b1000, 4'b1000, 2'd3, 1, 8'd0);
        add(0, 4'b1000, 4'b1000, 2'd3, 1, 8'd1);
        add(0, 4'b1000, 4'b1000, 2'd3, 1, 8'd2);
        add(1, 4'b1111, 4'b0000, 2'd0, 0, 8'd0);
        add(0, 4'b1111, 4'b0001, 2'd0, 1, 8'd0);
        // idle keeps sel; ptr left at 3 by the release of owner 2
        add(0, 4'b0100, 4'b0100, 2'd2, 1, 8'd0);
        add(0, 4'b0000, 4'b0000, 2'd2, 0, 8'd0);
        add(0, 4'b0000, 4'b0000, 2'd2, 0, 8'd0);
        add(0, 4'b1001, 4'b1000, 2'd3, 1, 8'd0);
        // owner drops on the same edge the limit is hit
        add(0, 4'b1111, 4'b1000, 2'd3, 1, 8'd1);
        add(0, 4'b1111, 4'b1000, 2'd3, 1, 8'd2);
        add(0, 4'b1111, 4'b1000, 2'd3, 1, 8'd3);
        add(0, 4'b0111, 4'b0001, 2'd0, 1, 8'd0);

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].req);
            chk("gnt", i, {4'b0, gnt4}, {4'b0, vecs[i].gnt});
            chk("sel", i, {6'b0, sel4}, {6'b0, vecs[i].sel});
            chk("valid", i, {7'b0, valid4}, {7'b0, vecs[i].valid});
            chk("hold_cnt", i, hold4, vecs[i].hold);
            chk("valid_eq_or_gnt", i, {7'b0, valid4}, {7'b0, |gnt4});
        end

        // limit disabled: owner 0 keeps the grant despite requester 3
        step(1'b1, 4'b1001);
        chk("nolim_rst_gnt", 0, {4'b0, gnt0}, 8'h00);
        for (int k = 0; k < 12; k++) begin
            step(1'b0, 4'b1001);
            chk("nolim_gnt", k, {4'b0, gnt0}, 8'h01);
            chk("nolim_hold", k, hold0, 8'(k));
            if (k < 4) chk("lim_gnt", k, {4'b0, gnt4}, 8'h01);
            else if (k == 4) chk("lim_rotate", k, {4'b0, gnt4}, 8'h08);
        end
        for (int k = 12; k < 260; k++) step(1'b0, 4'b1001);
        chk("nolim_sat", 260, hold0, 8'd255);
        chk("nolim_sat_gnt", 260, {4'b0, gnt0}, 8'h01);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux_sel_arbiter_4.md
Name: mux_sel_arbiter_4

Overview:
- Round-robin arbiter that shares one 4:1 select-driven datapath mux among four requesters.
- Produces a registered one-hot grant and the matching 2-bit mux select.
- Enforces a maximum hold time so no requester can monopolise the shared path.
- Sits in front of the shared operand/result mux in the datapath. Its `sel` output drives the mux select directly.

Parameters:
- MAX_HOLD, 8, maximum consecutive granted cycles before forced rotation when another requester is waiting. 0 disables the limit. Legal range 0..255.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- req  input  4  level request per requester; bit i = requester i
- gnt  output 4  registered one-hot grant; all-zero when idle
- sel  output 2  registered mux select; equals index of the granted requester
- valid  output 1  high while any grant is active (equals |gnt)
- hold_cnt  output 8  cycles the current owner has held the grant, minus 1; 0 when idle

Behaviour:
- Reset (rst=1 at a clock edge):
  - gnt=0000, sel=00, valid=0, hold_cnt=0.
  - Internal priority pointer ptr=0, state=IDLE.
  - Reset mid-grant drops the grant on that edge, with no completion semantics.
- States: IDLE and BUSY. All outputs are registered; there is no combinational path from req to any output.
- Priority search (used in IDLE and for every re-arbitration): first requester with a set req bit, scanning cyclically from ptr: ptr, ptr+1, ptr+2, ptr+3, modulo 4.
- IDLE:
  - If req==0, stay in IDLE. sel holds its last value so the mux output stays stable; valid=0.
  - If req!=0, grant the winner w on the next edge: gnt=onehot(w), sel=w, valid=1, hold_cnt=0, state=BUSY.
  - Latency: req sampled at edge N gives gnt visible after edge N.
- BUSY, owner i; evaluated every edge in the order below:
  1. Release. If req[i]=0, the owner is released.
     - Pointer update: ptr=(i+1) mod 4.
     - If any other req bit is set, the winner is granted on the same edge (no idle bubble), hold_cnt=0.
     - Otherwise gnt=0000, valid=0, hold_cnt=0, state=IDLE.
  2. Forced rotation. Applies when req[i]=1, MAX_HOLD!=0, hold_cnt==MAX_HOLD-1, and any req[j], j!=i, is set.
     - Pointer update: ptr=(i+1) mod 4.
     - The winner among the others is granted on that edge, hold_cnt=0.
     - The preempted requester keeps its request and re-enters arbitration normally.
  3. Hold limit reached with no one waiting. Grant is kept and hold_cnt saturates at MAX_HOLD-1; it does not wrap.
  4. Otherwise. Grant is kept and hold_cnt increments, saturating at 255 when MAX_HOLD=0.
- Invariants:
  - gnt is always one-hot or zero.
  - When valid=1, sel==index(gnt).
  - Ownership changes only on a clock edge.
- Simultaneous events:
  - Owner dropping req on the same edge the hold limit is hit is treated as a release.
  - Multiple new requests are resolved purely by ptr order.
- ptr wraps 3→0.

Test Plan:
- Reset and idle: hold rst=1 for 2 cycles with req=1111, then release rst.
  - Required: gnt=0000, sel=00, valid=0 during reset.
  - Required: one edge after reset release, gnt=0001, sel=00.
- Round robin with release each cycle: req=1111, each owner drops req one cycle after its grant and reasserts afterwards.
  - Required grant order: 0001 → 0010 → 0100 → 1000 → 0001, with sel following 0,1,2,3,0 and valid never dropping.
- Back-to-back handover with no bubble: owner 2 holds, req=0110, then req[2] drops.
  - Required: next edge gnt=0010, sel=01, valid stays 1.
- Hold limit, MAX_HOLD=4: req[0] held high permanently, req[3] raised one cycle after grant0.
  - Required: gnt=0001 for exactly 4 cycles, hold_cnt 0,1,2,3, then gnt=1000, sel=11, hold_cnt=0.
  - Required: then gnt=0001 again after requester 3 releases.
- Saturation with no contender, MAX_HOLD=4: only req[1] held for 10 cycles.
  - Required: gnt=0010 throughout, hold_cnt 0,1,2,3,3,3…
- Mid-grant reset: owner 3 holds with hold_cnt=2, rst=1 for one cycle while req=1111.
  - Required: gnt=0000, hold_cnt=0 at that edge.
  - Required: next grant is 0001, because ptr has been reset to 0.
